// File: rtl/rv32v_hazard_unit_param.sv
// Hazard unit for an N-stage RV32V pipeline.
// Produces per-stage stall and flush vectors from busy, exception and CSR
// inputs. A small FSM holds flush for a configurable number of cycles, and a
// watchdog flags a vector-decode busy latch that never releases.
module rv32v_hazard_unit_param #(
  parameter int unsigned NUM_STAGES   = 5,
  parameter int unsigned DEC_STAGE    = 2,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_VBUSY    = 64
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NUM_STAGES-1:0] busy,
  input  logic [NUM_STAGES-1:0] exception_vec,
  input  logic                  csr_update,
  input  logic                  v_busy,
  input  logic                  v_decode_done,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  flush_active,
  output logic                  watchdog_err
);

  localparam int unsigned WD_W = $clog2(MAX_VBUSY + 1);
  localparam logic [3:0]      CNT_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX     = WD_W'(MAX_VBUSY);
  localparam logic [WD_W-1:0] WD_PRE     = WD_W'(MAX_VBUSY - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_STAGES-1:0] r_mask_q;
  logic [NUM_STAGES-1:0] w_mask_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [WD_W-1:0]       r_wd_cnt;
  logic                  r_wd_err;

  logic                  w_vdec_stall;
  logic [NUM_STAGES-1:0] w_stall_raw;
  logic [NUM_STAGES-1:0] w_ex_mask;
  logic [NUM_STAGES-1:0] w_csr_mask;
  logic [NUM_STAGES-1:0] w_evt_mask;
  logic                  w_evt;
  logic [NUM_STAGES-1:0] w_flush_raw;

  assign w_vdec_stall = v_busy & ~v_decode_done;

  // Suffix-OR from the oldest stage down: a busy stage back-pressures every
  // younger stage, and the oldest excepting stage flushes itself and all
  // younger ones, which keeps both vectors contiguous from bit 0.
  always_comb begin : raw_masks
    logic v_run_busy;
    logic v_run_exc;
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    v_run_busy  = 1'b0;
    v_run_exc   = 1'b0;
    w_stall_raw = '0;
    w_ex_mask   = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      v_run_busy     = v_run_busy | busy[i];
      v_run_exc      = v_run_exc | exception_vec[i];
      w_stall_raw[i] = v_run_busy;
      w_ex_mask[i]   = v_run_exc;
      if (i <= int'(DEC_STAGE)) begin
        w_stall_raw[i] = v_run_busy | w_vdec_stall;
      end
    end
  end

  // A retiring CSR write refetches everything younger than the oldest stage.
  assign w_csr_mask = csr_update ? {1'b0, {(NUM_STAGES - 1){1'b1}}} : '0;
  assign w_evt_mask = w_ex_mask | w_csr_mask;
  assign w_evt      = |w_evt_mask;

  // Flush-hold FSM: next state, held mask, hold counter and raw flush vector.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask_q;
    w_cnt_nxt   = r_cnt;
    w_flush_raw = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_evt) begin
          w_flush_raw = w_evt_mask;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = ST_FLUSH;
            w_mask_nxt  = w_evt_mask;
            w_cnt_nxt   = CNT_RELOAD;
          end
        end
      end
      ST_FLUSH: begin
        w_flush_raw = r_mask_q | w_evt_mask;
        if (w_evt) begin
          // A new redirect widens the mask and restarts the hold window.
          w_mask_nxt = r_mask_q | w_evt_mask;
          w_cnt_nxt  = CNT_RELOAD;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_IDLE;
          w_mask_nxt  = '0;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_mask_nxt  = '0;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // FSM state, held flush mask and hold counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= ST_IDLE;
      r_mask_q <= '0;
      r_cnt    <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state  <= w_state_nxt;
      r_mask_q <= w_mask_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Watchdog: count consecutive unfinished vector-busy cycles, flag sticky.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wd_cnt <= '0;
      r_wd_err <= 1'b0;
    end else if (w_vdec_stall) begin
      if (r_wd_cnt != WD_MAX) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
      if (r_wd_cnt == WD_PRE) begin
        r_wd_err <= 1'b1;
      end
    end else begin
      r_wd_cnt <= '0;
    end
  end

  // Flush dominates stall; both read zero while reset is asserted so a
  // reset mid-flush is visible immediately rather than at the next edge.
  assign flush        = nRST ? w_flush_raw : '0;
  assign stall        = nRST ? (w_stall_raw & ~w_flush_raw) : '0;
  assign flush_active = (r_state == ST_FLUSH);
  assign watchdog_err = r_wd_err;

endmodule

// File: tb/tb_rv32v_hazard_unit_param.sv
// Directed bench for rv32v_hazard_unit_param with NUM_STAGES=5, DEC_STAGE=2,
// FLUSH_CYCLES=2, MAX_VBUSY=8. Inputs change 1 ns after a rising edge and
// outputs are sampled 1 ns later, well clear of either clock edge.
module tb_rv32v_hazard_unit_param;

  localparam int NS = 5;

  logic          CLK;
  logic          nRST;
  logic [NS-1:0] busy;
  logic [NS-1:0] exception_vec;
  logic          csr_update;
  logic          v_busy;
  logic          v_decode_done;
  logic [NS-1:0] stall;
  logic [NS-1:0] flush;
  logic          flush_active;
  logic          watchdog_err;

  int n_checks = 0;
  int n_errors = 0;

  rv32v_hazard_unit_param #(
    .NUM_STAGES  (NS),
    .DEC_STAGE   (2),
    .FLUSH_CYCLES(2),
    .MAX_VBUSY   (8)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .busy         (busy),
    .exception_vec(exception_vec),
    .csr_update   (csr_update),
    .v_busy       (v_busy),
    .v_decode_done(v_decode_done),
    .stall        (stall),
    .flush        (flush),
    .flush_active (flush_active),
    .watchdog_err (watchdog_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Sample point after inputs settle.
  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    busy          = '0;
    exception_vec = '0;
    csr_update    = 1'b0;
    v_busy        = 1'b0;
    v_decode_done = 1'b0;
  endtask

  initial begin
    clear_inputs();
    nRST = 1'b0;
    busy = 5'b00001;
    #12;
    // Reset state: combinational outputs are forced low even with busy set.
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_fa", 32'(flush_active), 32'h0);
    check("rst_wd", 32'(watchdog_err), 32'h0);
    nRST = 1'b1;

    // 1: busy in stage 3 stalls stages 0..3.
    tick();
    busy = 5'b01000;
    settle();
    check("t1_stall", 32'(stall), 32'h0F);
    check("t1_flush", 32'(flush), 32'h00);
    check("t1_fa", 32'(flush_active), 32'h0);

    // 2: exception in stage 2 with memory busy.
    tick();
    busy          = 5'b10000;
    exception_vec = 5'b00100;
    settle();
    check("t2_c0_flush", 32'(flush), 32'h07);
    check("t2_c0_stall", 32'(stall), 32'h18);
    check("t2_c0_fa", 32'(flush_active), 32'h0);
    tick();
    exception_vec = '0;
    settle();
    check("t2_c1_flush", 32'(flush), 32'h07);
    check("t2_c1_fa", 32'(flush_active), 32'h1);
    check("t2_c1_stall", 32'(stall), 32'h18);
    tick();
    settle();
    check("t2_c2_flush", 32'(flush), 32'h00);
    check("t2_c2_fa", 32'(flush_active), 32'h0);
    check("t2_c2_stall", 32'(stall), 32'h1F);

    // 3a: CSR plus exception in stage 3.
    tick();
    busy          = '0;
    csr_update    = 1'b1;
    exception_vec = 5'b01000;
    settle();
    check("t3a_c0_flush", 32'(flush), 32'h0F);
    tick();
    csr_update    = 1'b0;
    exception_vec = '0;
    settle();
    check("t3a_c1_flush", 32'(flush), 32'h0F);
    check("t3a_c1_fa", 32'(flush_active), 32'h1);
    tick();
    settle();
    check("t3a_c2_flush", 32'(flush), 32'h00);

    // 3b: CSR plus exception in the oldest stage flushes everything.
    tick();
    csr_update    = 1'b1;
    exception_vec = 5'b10000;
    settle();
    check("t3b_c0_flush", 32'(flush), 32'h1F);
    tick();
    csr_update    = 1'b0;
    exception_vec = '0;
    settle();
    check("t3b_c1_flush", 32'(flush), 32'h1F);
    tick();
    settle();
    check("t3b_c2_flush", 32'(flush), 32'h00);

    // CSR alone flushes all but the oldest stage.
    tick();
    csr_update = 1'b1;
    settle();
    check("csr_only_flush", 32'(flush), 32'h0F);
    tick();
    csr_update = 1'b0;
    tick();
    settle();
    check("csr_only_idle", 32'(flush_active), 32'h0);

    // Multiple exception bits resolve to the highest index.
    tick();
    exception_vec = 5'b00101;
    busy          = 5'b00010;
    settle();
    check("multi_exc_flush", 32'(flush), 32'h07);
    check("multi_exc_stall", 32'(stall), 32'h00);
    tick();
    exception_vec = '0;
    busy          = '0;
    tick();

    // 4: second event while in FLUSH restarts the hold counter.
    tick();
    exception_vec = 5'b00010;
    settle();
    check("t4_t0_flush", 32'(flush), 32'h03);
    tick();
    exception_vec = 5'b10000;
    settle();
    check("t4_t1_flush", 32'(flush), 32'h1F);
    check("t4_t1_fa", 32'(flush_active), 32'h1);
    tick();
    exception_vec = '0;
    settle();
    check("t4_t2_flush", 32'(flush), 32'h1F);
    check("t4_t2_fa", 32'(flush_active), 32'h1);
    tick();
    settle();
    check("t4_t3_flush", 32'(flush), 32'h00);
    check("t4_t3_fa", 32'(flush_active), 32'h0);

    // 5a: vector busy held 10 cycles without completion.
    tick();
    v_busy        = 1'b1;
    v_decode_done = 1'b0;
    settle();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("t5a_stall_c%0d", c), 32'(stall), 32'h07);
      check($sformatf("t5a_wd_c%0d", c), 32'(watchdog_err), (c >= 8) ? 32'h1 : 32'h0);
      tick();
      settle();
    end
    v_busy = 1'b0;
    settle();
    check("t5a_stall_drop", 32'(stall), 32'h00);
    tick();
    settle();
    check("t5a_wd_sticky", 32'(watchdog_err), 32'h1);

    // 6: reset asserted during FLUSH cycle 1 aborts the flush immediately.
    tick();
    busy          = 5'b00010;
    exception_vec = 5'b00100;
    tick();
    exception_vec = '0;
    settle();
    check("t6_pre_fa", 32'(flush_active), 32'h1);
    nRST = 1'b0;
    settle();
    check("t6_rst_flush", 32'(flush), 32'h00);
    check("t6_rst_stall", 32'(stall), 32'h00);
    check("t6_rst_fa", 32'(flush_active), 32'h0);
    check("t6_rst_wd", 32'(watchdog_err), 32'h0);
    tick();
    nRST = 1'b1;
    tick();
    settle();
    check("t6_post_flush", 32'(flush), 32'h00);
    check("t6_post_fa", 32'(flush_active), 32'h0);
    check("t6_post_stall", 32'(stall), 32'h03);
    check("t6_post_wd", 32'(watchdog_err), 32'h0);

    // 5b: same busy run with v_decode_done pulsed at cycle 5.
    tick();
    busy   = '0;
    v_busy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      v_decode_done = (c == 5);
      settle();
      check($sformatf("t5b_stall_c%0d", c), 32'(stall), (c == 5) ? 32'h00 : 32'h07);
      check($sformatf("t5b_wd_c%0d", c), 32'(watchdog_err), 32'h0);
      tick();
    end
    clear_inputs();
    tick();
    settle();
    check("t5b_wd_end", 32'(watchdog_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
